psum_deskew_collector: RTL and testbench
========================================

// Module: psum_deskew_collector
// PURPOSE
//  Output-side counterpart of the activation feed: receives skewed per-column partial sums from the
//  bottom of the systolic array plus unskewed compensation-shadow-array results, de-skews them, adds
//  compensation per element, stores a SIZE x SIZE row-major result tile, then drains it over valid/ready.
// PARAMETERS
//  SIZE       8                  array dimension (rows = columns)
//  PSUM_W     16                 width of one partial sum / compensation term (two's complement)
//  RES_W      PSUM_W+1           stored/output result width (sum never overflows)
//  MEM_SIZE   SIZE*SIZE          result tile entries
//  ADDR_W     $clog2(MEM_SIZE)   result address width
//  ROW_W      $clog2(SIZE)+1     per-column row counter width (counts 0..SIZE)
// PORTS
//  clk         in   1             clock, rising edge
//  rst         in   1             asynchronous, active-high reset
//  start       in   1             pulse: clear tile state, enter COLLECT (legal in any state)
//  Psum_in     in   SIZE*PSUM_W   column j at [j*PSUM_W +: PSUM_W]
//  Psum_valid  in   SIZE          bit j: Psum_in column j carries the next row of column j
//  Comp_in     in   SIZE*PSUM_W   compensation for all columns of the next row, column j at [j*PSUM_W +: PSUM_W]
//  Comp_valid  in   1             Comp_in carries the next compensation row
//  Out_ready   in   1             downstream accepts Out_data
//  Out_valid   out  1             Out_data/Out_addr valid
//  Out_data    out  RES_W         result element
//  Out_addr    out  ADDR_W        row*SIZE + col of Out_data
//  busy        out  1             state != IDLE
//  done        out  1             one-cycle pulse after last element accepted
//  err         out  1             sticky: write to a full column/comp row; cleared by start or rst
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; row counters, comp row counter, read pointer 0; comp store 0.
//  States: IDLE -start-> COLLECT -all cols full-> DRAIN -last beat accepted-> IDLE (done=1 that cycle).
//  start in any state: counters, err cleared, state COLLECT, Out_valid 0 next cycle (abort; drain lost).
//  COLLECT, compensation: on Comp_valid with comp_row<SIZE, store Comp_in as comp[comp_row][*], comp_row++.
//   Comp_valid with comp_row==SIZE: ignored, err<=1.
//  COLLECT, psum: per column j independently, on Psum_valid[j] with row_cnt[j]<SIZE:
//   Mem[row_cnt[j]*SIZE+j] <= sext(psum_j) + sext(comp[row_cnt[j]][j]); row_cnt[j]++.
//   Psum_valid[j] with row_cnt[j]==SIZE: ignored, err<=1. Several columns may write in one cycle.
//  Ordering: comp for row r precedes or coincides with psum (r,j). Same-cycle Comp_valid for row r and
//   Psum_valid[j] for row r: bypass Comp_in column j into the sum (not stale store).
//   Psum arriving before its comp row (comp_row<=r, no bypass): treated as comp 0, err<=1.
//  Psum_valid/Comp_valid outside COLLECT: ignored, no err.
//  COLLECT->DRAIN: at the edge where registered row_cnt[j]==SIZE for all j; same edge loads
//   Out_data<=Mem[0], Out_addr<=0, Out_valid<=1. First DRAIN cycle already presents element 0.
//  DRAIN: Out_data/Out_addr held stable while Out_valid&&!Out_ready. On Out_valid&&Out_ready with
//   Out_addr<MEM_SIZE-1: load Mem[Out_addr+1] next edge (zero-bubble, one beat/cycle at full ready).
//   Accept of addr MEM_SIZE-1: Out_valid<=0, state IDLE, done<=1 for one cycle.
//  Latency: final psum write edge -> Out_valid high 1 cycle later; element k out at earliest k cycles after.
//  Arithmetic: signed, sign-extended to RES_W, no saturation; Out_data 0 when Out_valid 0.
// STRUCTURE
//  Shared package/include (tpu_pkg): SIZE, PSUM_W, RES_W derivation, state encoding
//   (IDLE=2'd0, COLLECT=2'd1, DRAIN=2'd2).
//  Sub-module psum_col_tracker (x SIZE): row counter, full flag, overflow strobe, write-address gen.
//  Top: FSM, comp store (SIZE x SIZE x PSUM_W), result memory, adders, drain pointer.
// TESTING
//  1 Skew fill: start; comp rows 0..7 = 0 at t=0..7; psum(r,j)=r*8+j at t=2+r+j; Out_ready=1
//    -> 64 beats, Out_addr 0..63 consecutive, Out_data==Out_addr, done one pulse after beat 63.
//  2 Compensation add: comp(r,j)=-1, psum(r,j)=100, comp row r same cycle as psum(r,0) (bypass)
//    -> all Out_data 99; err stays 0.
//  3 Backpressure: as test 1, Out_ready toggled 1,0,0,1... -> data/addr stable while stalled,
//    no element dropped or duplicated, 64 accepted beats.
//  4 Overflow: 9th Psum_valid[3] after column 3 full, and 9th Comp_valid -> err=1, tile
//    contents unchanged vs test 1; start clears err.
//  5 Abort: start asserted mid-DRAIN at Out_addr=20 -> Out_valid 0 next cycle, state COLLECT,
//    fresh tile collected and drained from addr 0.
//  6 Reset mid-COLLECT: rst pulse asynchronously -> all outputs 0 immediately, busy 0,
//    Psum_valid ignored until start.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared parameters, state encoding and helpers for the systolic-array output path.
package tpu_pkg;

  localparam int unsigned SIZE     = 8;
  localparam int unsigned PSUM_W   = 16;
  localparam int unsigned RES_W    = PSUM_W + 1;
  localparam int unsigned MEM_SIZE = SIZE * SIZE;
  localparam int unsigned ADDR_W   = $clog2(MEM_SIZE);
  localparam int unsigned ROW_W    = $clog2(SIZE) + 1;
  localparam int unsigned IDX_W    = $clog2(SIZE);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDrain   = 2'd2
  } state_e;

  function automatic logic [RES_W-1:0] sext(input logic [PSUM_W-1:0] v);
    return {{(RES_W - PSUM_W){v[PSUM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/psum_col_tracker.sv
// Per-column row counter: tracks how many rows of one column have landed and where the next goes.
module psum_col_tracker
  import tpu_pkg::*;
#(
  parameter int unsigned Col = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              valid_i,
  output logic [ROW_W-1:0]  row_o,
  output logic              full_o,
  output logic              wr_o,
  output logic              ovf_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ROW_W-1:0] row_q, row_d;

  assign full_o = (row_q == ROW_W'(SIZE));
  assign wr_o   = valid_i & ~full_o;
  assign ovf_o  = valid_i & full_o;
  assign row_o  = row_q;
  // Row-major tile address; only meaningful while the column is not full.
  assign addr_o = ADDR_W'(32'(row_q) * SIZE + Col);

  always_comb begin
    row_d = row_q;
    if (clear_i) begin
      row_d = '0;
    end else if (wr_o) begin
      row_d = row_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/psum_deskew_collector.sv
// De-skews per-column partial sums, adds per-element compensation, stores the tile and
// drains it in row-major order over a valid/ready port.
module psum_deskew_collector
  import tpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SIZE*PSUM_W-1:0]   Psum_in,
  input  logic [SIZE-1:0]          Psum_valid,
  input  logic [SIZE*PSUM_W-1:0]   Comp_in,
  input  logic                     Comp_valid,
  input  logic                     Out_ready,
  output logic                     Out_valid,
  output logic [RES_W-1:0]         Out_data,
  output logic [ADDR_W-1:0]        Out_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  state_e state_q, state_d;

  logic [PSUM_W-1:0] comp_q [SIZE][SIZE];
  logic [RES_W-1:0]  mem_q  [MEM_SIZE];
  logic [ROW_W-1:0]  comp_row_q, comp_row_d;
  logic              out_valid_q, out_valid_d;
  logic [RES_W-1:0]  out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d, addr_nxt;
  logic              done_q, done_d, err_q, err_d;

  logic              collecting, comp_wr, comp_ovf;
  logic [SIZE-1:0]   wr, ovf, full, miss;
  logic [ROW_W-1:0]  row   [SIZE];
  logic [ADDR_W-1:0] waddr [SIZE];
  logic [RES_W-1:0]  wdata [SIZE];

  // start takes priority over any same-cycle data so an abort never half-fills the new tile.
  assign collecting = (state_q == StCollect) && !start;
  assign comp_wr    = collecting && Comp_valid && (comp_row_q < ROW_W'(SIZE));
  assign comp_ovf   = collecting && Comp_valid && (comp_row_q == ROW_W'(SIZE));
  assign addr_nxt   = out_addr_q + 1'b1;

  for (genvar j = 0; j < SIZE; j++) begin : g_col
    psum_col_tracker #(
      .Col(j)
    ) u_trk (
      .clk    (clk),
      .rst    (rst),
      .clear_i(start),
      .valid_i(Psum_valid[j] & collecting),
      .row_o  (row[j]),
      .full_o (full[j]),
      .wr_o   (wr[j]),
      .ovf_o  (ovf[j]),
      .addr_o (waddr[j])
    );
  end

  // Compensation source: same-cycle bypass, stored row, or missing (treated as zero).
  always_comb begin
    miss = '0;
    for (int j = 0; j < SIZE; j++) begin
      logic [PSUM_W-1:0] c;
      if (comp_wr && (comp_row_q == row[j])) begin
        c = Comp_in[j*PSUM_W +: PSUM_W];
      end else if (comp_row_q > row[j]) begin
        c = comp_q[row[j][IDX_W-1:0]][j];
      end else begin
        c = '0;
        miss[j] = wr[j];
      end
      wdata[j] = sext(Psum_in[j*PSUM_W +: PSUM_W]) + sext(c);
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    done_d      = 1'b0;
    err_d       = err_q | (|ovf) | comp_ovf | (|miss);
    comp_row_d  = comp_row_q + ROW_W'(comp_wr);
    if (start) begin
      state_d     = StCollect;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_addr_d  = '0;
      err_d       = 1'b0;
      comp_row_d  = '0;
    end else begin
      case (state_q)
        StCollect: begin
          if (&full) begin
            state_d     = StDrain;
            out_valid_d = 1'b1;
            out_data_d  = mem_q[0];
            out_addr_d  = '0;
          end
        end
        StDrain: begin
          if (out_valid_q && Out_ready) begin
            if (out_addr_q == ADDR_W'(MEM_SIZE - 1)) begin
              state_d     = StIdle;
              out_valid_d = 1'b0;
              out_data_d  = '0;
              out_addr_d  = '0;
              done_d      = 1'b1;
            end else begin
              out_data_d = mem_q[addr_nxt];
              out_addr_d = addr_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      comp_row_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      comp_row_q  <= comp_row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int j = 0; j < SIZE; j++) begin
          comp_q[r][j] <= '0;
        end
      end
    end else if (comp_wr) begin
      for (int j = 0; j < SIZE; j++) begin
        comp_q[comp_row_q[IDX_W-1:0]][j] <= Comp_in[j*PSUM_W +: PSUM_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < SIZE; j++) begin
      if (wr[j]) begin
        mem_q[waddr[j]] <= wdata[j];
      end
    end
  end

  assign Out_valid = out_valid_q;
  assign Out_data  = out_data_q;
  assign Out_addr  = out_addr_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_psum_deskew_collector.sv
// Directed bench for psum_deskew_collector: skewed fills, compensation, backpressure,
// overflow, abort and asynchronous reset.
module tb_psum_deskew_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] Psum_in;
  logic [7:0]   Psum_valid;
  logic [127:0] Comp_in;
  logic         Comp_valid;
  logic         Out_ready;
  logic         Out_valid;
  logic [16:0]  Out_data;
  logic [5:0]   Out_addr;
  logic         busy;
  logic         done;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_mem [64];

  psum_deskew_collector u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .Psum_in   (Psum_in),
    .Psum_valid(Psum_valid),
    .Comp_in   (Comp_in),
    .Comp_valid(Comp_valid),
    .Out_ready (Out_ready),
    .Out_valid (Out_valid),
    .Out_data  (Out_data),
    .Out_addr  (Out_addr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic clear_inputs();
    Psum_valid = '0;
    Psum_in    = '0;
    Comp_valid = 1'b0;
    Comp_in    = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: comp 0 at t=r, psum r*8+j at t=2+r+j
  // mode 1: comp -1 at t=2+r (bypass for column 0), psum 100
  // mode 2: mode 0 plus a 9th comp row at t=9 and an extra column-3 psum at t=14
  task automatic collect(input int mode);
    for (int t = 0; t < 17; t++) begin
      @(negedge clk);
      clear_inputs();
      for (int r = 0; r < 8; r++) begin
        if (t == ((mode == 1) ? 2 + r : r)) begin
          Comp_valid = 1'b1;
          for (int j = 0; j < 8; j++) Comp_in[j*16 +: 16] = (mode == 1) ? 16'hFFFF : 16'h0000;
        end
      end
      if (mode == 2 && t == 9) Comp_valid = 1'b1;
      for (int j = 0; j < 8; j++) begin
        int r;
        r = t - 2 - j;
        if (r >= 0 && r < 8) begin
          Psum_valid[j]     = 1'b1;
          Psum_in[j*16 +: 16] = (mode == 1) ? 16'd100 : 16'(r * 8 + j);
        end
      end
      if (mode == 2 && t == 14) begin
        Psum_valid[3]   = 1'b1;
        Psum_in[48 +: 16] = 16'h7777;
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic set_exp(input int mode);
    for (int k = 0; k < 64; k++) exp_mem[k] = (mode == 1) ? 17'd99 : 17'(k);
  endtask

  // pat 0: always ready; pat 1: ready 1,0,0,1,0,0...
  task automatic drain(input int pat);
    int beats;
    int cyc;
    logic rdy;
    beats = 0;
    cyc   = 0;
    while (beats < 64 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      check_eq("drain_valid", 32'(Out_valid), 32'd1);
      rdy       = (pat == 0) || (((cyc - 1) % 3) == 0);
      Out_ready = rdy;
      if (Out_valid) begin
        check_eq("drain_addr", 32'(Out_addr), 32'(beats));
        check_eq("drain_data", 32'(Out_data), 32'(exp_mem[beats]));
        if (rdy) beats++;
      end
    end
    check_eq("beat_count", 32'(beats), 32'd64);
    @(negedge clk);
    Out_ready = 1'b0;
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("valid_after_last", 32'(Out_valid), 32'd0);
    check_eq("data_after_last", 32'(Out_data), 32'd0);
    check_eq("busy_after_last", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    logic found;
    rst       = 1'b1;
    start     = 1'b0;
    Out_ready = 1'b0;
    clear_inputs();
    #3;
    check_eq("rst_valid", 32'(Out_valid), 32'd0);
    check_eq("rst_data", 32'(Out_data), 32'd0);
    check_eq("rst_addr", 32'(Out_addr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Skew fill
    pulse_start();
    check_eq("busy_after_start", 32'(busy), 32'd1);
    collect(0);
    check_eq("valid_before_drain", 32'(Out_valid), 32'd0);
    set_exp(0);
    drain(0);
    check_eq("t1_err", 32'(err), 32'd0);

    // Compensation add with same-cycle bypass
    pulse_start();
    collect(1);
    check_eq("t2_err_collect", 32'(err), 32'd0);
    set_exp(1);
    drain(0);
    check_eq("t2_err_drain", 32'(err), 32'd0);

    // Backpressure
    pulse_start();
    collect(0);
    set_exp(0);
    drain(1);

    // Overflow on a full column and a 9th comp row
    pulse_start();
    collect(2);
    check_eq("t4_err_set", 32'(err), 32'd1);
    set_exp(0);
    drain(0);
    check_eq("t4_err_sticky", 32'(err), 32'd1);
    pulse_start();
    check_eq("t4_err_cleared", 32'(err), 32'd0);

    // Abort mid-drain at address 20
    collect(0);
    Out_ready = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (Out_valid && Out_addr == 6'd20) found = 1'b1;
    end
    check_eq("abort_reach20", 32'(found), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    Out_ready = 1'b0;
    check_eq("abort_valid", 32'(Out_valid), 32'd0);
    check_eq("abort_data", 32'(Out_data), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd1);
    collect(1);
    set_exp(1);
    drain(0);
    check_eq("t5_err", 32'(err), 32'd0);

    // Asynchronous reset mid-collect
    pulse_start();
    @(negedge clk);
    Psum_valid = 8'h01;
    Psum_in    = 128'd5;
    @(negedge clk);
    clear_inputs();
    check_eq("miss_comp_err", 32'(err), 32'd1);
    check_eq("t6_busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_err", 32'(err), 32'd0);
    check_eq("arst_valid", 32'(Out_valid), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      Psum_valid = 8'hFF;
      Comp_valid = 1'b1;
    end
    @(negedge clk);
    clear_inputs();
    check_eq("idle_ignore_busy", 32'(busy), 32'd0);
    check_eq("idle_ignore_err", 32'(err), 32'd0);
    pulse_start();
    collect(0);
    set_exp(0);
    drain(0);
    check_eq("t6_err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
